// File: rtl/vx_tcu_drl_acc_seq.sv
// Purpose: sequences one multi-step dot-product request through an external combinational accumulator.
// Latency: response valid the cycle after the last operand fire (the cycle after accept when steps==0).
// Backpressure: one request in flight; operands stall freely in RUN, response held stable until rsp_ready.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   req_*             - request: id, step count (clamped to MAXK), C-term significand and sticky
//   op_*              - per-step product operands: N-1 lanes of significand, sticky and lane mask
//   acc_* (out)       - lanes driven to the combinational accumulator; C lane only on step 0
//   acc_sig, acc_sticky_in - accumulator result for the lanes currently driven
//   rsp_*             - accumulated significand/sticky with the request id
//   busy              - high whenever a request is in flight or awaiting rsp_ready
module vx_tcu_drl_acc_seq #(
  parameter           INSTANCE_ID = "",
  parameter int       N           = 5,
  parameter int       WI          = 26,
  parameter int       WO          = 30,
  parameter int       MAXK        = 8,
  localparam int      SW          = $clog2(MAXK + 1)
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_id,
  input  logic [SW-1:0]         req_steps,
  input  logic [WI-1:0]         req_c_sig,
  input  logic                  req_c_sticky,

  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [(N-1)*WI-1:0]   op_sigs,
  input  logic [N-2:0]          op_sticky,
  input  logic [N-2:0]          op_mask,

  output logic                  acc_valid,
  output logic [31:0]           acc_req_id,
  output logic [N-2:0]          acc_lane_mask,
  output logic [N*WI-1:0]       acc_sigs,
  output logic [N-1:0]          acc_sticky,
  input  logic [WO-1:0]         acc_sig,
  input  logic                  acc_sticky_in,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_id,
  output logic [WO-1:0]         rsp_sig,
  output logic                  rsp_sticky,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [SW-1:0] MAXK_SW = SW'(MAXK);

  state_e          state_q,    state_d;
  logic [31:0]     id_q,       id_d;
  logic [SW-1:0]   steps_q,    steps_d;
  logic [WI-1:0]   c_sig_q,    c_sig_d;
  logic            c_sticky_q, c_sticky_d;
  logic [WO-1:0]   sum_q,      sum_d;
  logic            sticky_q,   sticky_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;

  logic [SW-1:0]   steps_clamped;
  logic            last_step;

  assign steps_clamped = (req_steps > MAXK_SW) ? MAXK_SW : req_steps;
  assign last_step     = (step_cnt_q == steps_q - SW'(1));

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    steps_d       = steps_q;
    c_sig_d       = c_sig_q;
    c_sticky_d    = c_sticky_q;
    sum_d         = sum_q;
    sticky_d      = sticky_q;
    step_cnt_d    = step_cnt_q;

    req_ready     = 1'b0;
    op_ready      = 1'b0;
    acc_valid     = 1'b0;
    acc_req_id    = id_q;
    acc_lane_mask = '0;
    acc_sigs      = '0;
    acc_sticky    = '0;
    rsp_valid     = 1'b0;
    rsp_id        = '0;
    rsp_sig       = '0;
    rsp_sticky    = 1'b0;
    busy          = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          id_d       = req_id;
          steps_d    = steps_clamped;
          c_sig_d    = req_c_sig;
          c_sticky_d = req_c_sticky;
          step_cnt_d = '0;
          if (steps_clamped == '0) begin
            // Nothing to accumulate: the result is just the C term.
            sum_d    = {{(WO-WI){req_c_sig[WI-1]}}, req_c_sig};
            sticky_d = req_c_sticky;
            state_d  = ST_DONE;
          end else begin
            sum_d    = '0;
            sticky_d = 1'b0;
            state_d  = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        op_ready                     = 1'b1;
        acc_valid                    = op_valid;
        acc_lane_mask                = op_mask;
        acc_sigs[(N-1)*WI-1:0]       = op_sigs;
        acc_sticky[N-2:0]            = op_sticky;
        // The C term is folded in exactly once, on the first step.
        if (step_cnt_q == '0) begin
          acc_sigs[(N-1)*WI +: WI]   = c_sig_q;
          acc_sticky[N-1]            = c_sticky_q;
        end
        if (op_valid) begin
          sum_d      = sum_q + acc_sig;
          sticky_d   = sticky_q | acc_sticky_in;
          step_cnt_d = step_cnt_q + SW'(1);
          if (last_step) begin
            state_d  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        rsp_valid  = 1'b1;
        rsp_id     = id_q;
        rsp_sig    = sum_q;
        rsp_sticky = sticky_q;
        if (rsp_ready) begin
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset silences every output, including req_ready, for its full duration.
    if (reset) begin
      req_ready     = 1'b0;
      op_ready      = 1'b0;
      acc_valid     = 1'b0;
      acc_req_id    = '0;
      acc_lane_mask = '0;
      acc_sigs      = '0;
      acc_sticky    = '0;
      rsp_valid     = 1'b0;
      rsp_id        = '0;
      rsp_sig       = '0;
      rsp_sticky    = 1'b0;
      busy          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      steps_q    <= '0;
      c_sig_q    <= '0;
      c_sticky_q <= 1'b0;
      sum_q      <= '0;
      sticky_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      steps_q    <= steps_d;
      c_sig_q    <= c_sig_d;
      c_sticky_q <= c_sticky_d;
      sum_q      <= sum_d;
      sticky_q   <= sticky_d;
      step_cnt_q <= step_cnt_d;
    end
  end

`ifdef DBG_TRACE_TCU
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready)
        $display("%t: %s acc-seq req id=0x%0h steps=%0d c=0x%0h c_sticky=%0b",
                 $time, INSTANCE_ID, req_id, steps_clamped, req_c_sig, req_c_sticky);
      if (op_valid && op_ready)
        $display("%t: %s acc-seq step id=0x%0h cnt=%0d mask=0x%0h acc=0x%0h sticky=%0b",
                 $time, INSTANCE_ID, id_q, step_cnt_q, op_mask, acc_sig, acc_sticky_in);
      if (rsp_valid && rsp_ready)
        $display("%t: %s acc-seq rsp id=0x%0h sig=0x%0h sticky=%0b",
                 $time, INSTANCE_ID, rsp_id, rsp_sig, rsp_sticky);
    end
  end
`endif

endmodule
